// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side driver for the 64-bit ALU.
// Accepts one command at a time, holds ALU inputs for the ALU's registered
// latency, captures the result and returns it with the command tag.
// Optional build macro ALU_SEQ_CHECK_EN adds an internal reference model
// that flags results disagreeing with it on rsp_mismatch.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int         ALU_LATENCY = 2,
  parameter int         TAG_W       = 4,
  parameter logic [3:0] IDLE_OP     = 4'hF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [63:0]      alu_operand_A,
  output logic [63:0]      alu_operand_B,
  output logic [3:0]       alu_op,
  input  logic [63:0]      alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             rsp_mismatch,
  output logic [15:0]      op_count
);

  localparam int CNT_W = $clog2(ALU_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             legal;
  logic             capture;
  logic             handshake;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && (state == IDLE);
  assign legal     = (cmd_op <= 4'hA);
  assign capture   = (state == EXEC) && (cnt == CNT_W'(ALU_LATENCY));
  assign handshake = (state == RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: illegal opcodes bypass the ALU and respond immediately
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = legal ? EXEC : RESP;
      EXEC: if (capture) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter and tag latch for the command in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      tag_q <= cmd_tag;
    end else if (state == EXEC) begin
      cnt   <= cnt + 1'b1;
    end
  end

  // ALU input drive: operands keep last values, opcode parks on IDLE_OP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_operand_A <= '0;
      alu_operand_B <= '0;
      alu_op        <= IDLE_OP;
    end else if (accept && legal) begin
      alu_operand_A <= cmd_a;
      alu_operand_B <= cmd_b;
      alu_op        <= cmd_op;
    end else if (capture) begin
      alu_op        <= IDLE_OP;
    end
  end

  // Response capture: held stable through the whole RESP state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else if (accept && !legal) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= cmd_tag;
      rsp_err    <= 1'b1;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_tag    <= tag_q;
      rsp_err    <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       op_count <= '0;
    else if (handshake) op_count <= op_count + 16'd1;
  end

`ifdef ALU_SEQ_CHECK_EN
  function automatic logic [63:0] ref_result(input logic [3:0]  op,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
    logic signed [63:0] a_s;
    a_s = a;
    case (op)
      4'h0:    ref_result = a + b;
      4'h1:    ref_result = a - b;
      4'h2:    ref_result = a & b;
      4'h3:    ref_result = a | b;
      4'h4:    ref_result = a ^ b;
      4'h5:    ref_result = a << b[5:0];
      4'h6:    ref_result = a >> b[5:0];
      4'h7:    ref_result = a_s >>> b[5:0];
      4'h8:    ref_result = {63'd0, (a < b)};
      4'h9:    ref_result = {63'd0, (a == b)};
      4'hA:    ref_result = {63'd0, (a != b)};
      default: ref_result = '0;
    endcase
  endfunction

  // Self-check flag: compared at capture, cleared on handshake and illegal ops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rsp_mismatch <= 1'b0;
    else if (capture)
      rsp_mismatch <= (ref_result(alu_op, alu_operand_A, alu_operand_B) != alu_result);
    else if (handshake || (accept && !legal))
      rsp_mismatch <= 1'b0;
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: behavioural 2-stage ALU plus reference
// model, directed vectors, random commands, back-pressure, throughput, reset.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'h0;
  logic [63:0]      cmd_a = '0;
  logic [63:0]      cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [63:0]      alu_operand_A;
  logic [63:0]      alu_operand_B;
  logic [3:0]       alu_op;
  logic [63:0]      alu_result = '0;
  logic             alu_zero = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [63:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             rsp_mismatch;
  logic [15:0]      op_count;

  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;
  logic inject_xor = 1'b0;
  logic watch_idle_op = 1'b0;
  int   idle_op_viol = 0;

  alu_cmd_sequencer #(.ALU_LATENCY(2), .TAG_W(TAG_W), .IDLE_OP(4'hF)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU semantics
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    int sh;
    logic [63:0] r;
    sh = int'(b[5:0]);
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << sh;
      4'h6: r = a >> sh;
      4'h7: begin
        r = a >> sh;
        if (a[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
      end
      4'h8: r = (a < b) ? 64'd1 : 64'd0;
      4'h9: r = (a == b) ? 64'd1 : 64'd0;
      4'hA: r = (a != b) ? 64'd1 : 64'd0;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Behavioural ALU: two registered stages, optional wrong XOR result
  logic [63:0] alu_s1 = '0;
  always @(posedge clk) begin
    if (inject_xor && alu_op == 4'h4)
      alu_s1 <= ref_alu(alu_op, alu_operand_A, alu_operand_B) ^ 64'd1;
    else
      alu_s1 <= ref_alu(alu_op, alu_operand_A, alu_operand_B);
    alu_result <= alu_s1;
    alu_zero   <= (alu_s1 == 64'd0);
  end

  always @(negedge clk) begin
    if (watch_idle_op && alu_op !== 4'hF) idle_op_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Issue one command, optionally stall the response, then hand it off.
  task automatic run_cmd(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, input int hold,
                         output logic [63:0] res, output logic z, output logic [3:0] t,
                         output logic e, output logic m, output int lat,
                         output int unstable, output logic idle_after);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_op = 4'($urandom); cmd_a = {$urandom, $urandom};
    cmd_b = {$urandom, $urandom}; cmd_tag = 4'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    res = rsp_result; z = rsp_zero; t = rsp_tag; e = rsp_err; m = rsp_mismatch;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || cmd_ready || rsp_result !== res || rsp_zero !== z ||
          rsp_tag !== t || rsp_err !== e || rsp_mismatch !== m) unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    idle_after = cmd_ready && !rsp_valid;
    exp_count++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, alu_op, op_count} !== {1'b0, 4'hF, 16'h0}) begin
      failures++;
      $display("FAIL reset_ctrl got=%h exp=%h", {rsp_valid, alu_op, op_count}, {1'b0, 4'hF, 16'h0});
    end
    checks++;
    if ({alu_operand_A, alu_operand_B} !== 128'd0) begin
      failures++;
      $display("FAIL reset_operands got=%h exp=0", {alu_operand_A, alu_operand_B});
    end
    checks++;
    if ({rsp_result, rsp_zero, rsp_tag, rsp_err, rsp_mismatch} !== 71'd0) begin
      failures++;
      $display("FAIL reset_rsp got=%h exp=0", {rsp_result, rsp_zero, rsp_tag, rsp_err, rsp_mismatch});
    end
    reset_n = 1'b1;
    exp_count = 0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] r; logic z, e, m, ia; logic [3:0] t; int lat, us;
    run_cmd(4'h0, 64'd5, 64'd7, 4'd3, 0, r, z, t, e, m, lat, us, ia);
    checks++;
    if ({r, z, t, e} !== {64'd12, 1'b0, 4'd3, 1'b0}) begin
      failures++;
      $display("FAIL add_vec got=%h exp=%h", {r, z, t, e}, {64'd12, 1'b0, 4'd3, 1'b0});
    end
    checks++;
    if (lat != 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    checks++;
    if (op_count !== 16'd1) begin failures++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
    run_cmd(4'h1, 64'd9, 64'd9, 4'd5, 0, r, z, t, e, m, lat, us, ia);
    checks++;
    if ({r, z, t} !== {64'd0, 1'b1, 4'd5}) begin
      failures++;
      $display("FAIL sub_zero got=%h exp=%h", {r, z, t}, {64'd0, 1'b1, 4'd5});
    end
    run_cmd(4'h7, 64'h8000_0000_0000_0000, 64'd4, 4'd6, 0, r, z, t, e, m, lat, us, ia);
    checks++;
    if (r !== 64'hF800_0000_0000_0000) begin
      failures++;
      $display("FAIL sra_vec got=%h exp=%h", r, 64'hF800_0000_0000_0000);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] r; logic z, e, m, ia; logic [3:0] t; int lat, us;
    idle_op_viol = 0;
    watch_idle_op = 1'b1;
    run_cmd(4'hC, {$urandom, $urandom}, {$urandom, $urandom}, 4'd1, 0, r, z, t, e, m, lat, us, ia);
    watch_idle_op = 1'b0;
    checks++;
    if ({r, z, t, e} !== {64'd0, 1'b0, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL illegal_rsp got=%h exp=%h", {r, z, t, e}, {64'd0, 1'b0, 4'd1, 1'b1});
    end
    checks++;
    if (lat != 0) begin failures++; $display("FAIL illegal_latency got=%0d exp=0", lat); end
    checks++;
    if (idle_op_viol != 0) begin
      failures++;
      $display("FAIL illegal_alu_op cycles_not_idle=%0d exp=0", idle_op_viol);
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL illegal_op_count got=%0d exp=%0d", op_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] r, a, b; logic z, e, m, ia; logic [3:0] t; int lat, us;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    run_cmd(4'h3, a, b, 4'd9, 5, r, z, t, e, m, lat, us, ia);
    checks++;
    if (us != 0) begin failures++; $display("FAIL stall_stable unstable_cycles=%0d exp=0", us); end
    checks++;
    if (ia !== 1'b1) begin failures++; $display("FAIL stall_idle_after got=%b exp=1", ia); end
    checks++;
    if ({r, t} !== {a | b, 4'd9}) begin
      failures++;
      $display("FAIL stall_rsp got=%h exp=%h", {r, t}, {a | b, 4'd9});
    end
  endtask

  task automatic test_random();
    logic [63:0] r, a, b, er; logic z, e, m, ia, ez, ee; logic [3:0] t, op, tag;
    int lat, us, hold, elat;
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      tag = 4'($urandom);
      hold = $urandom_range(0, 3);
      run_cmd(op, a, b, tag, hold, r, z, t, e, m, lat, us, ia);
      if (op <= 4'hA) begin
        er = ref_alu(op, a, b); ez = (er == 64'd0); ee = 1'b0; elat = 3;
      end else begin
        er = 64'd0; ez = 1'b0; ee = 1'b1; elat = 0;
      end
      checks++;
      if ({r, z, t, e, m} !== {er, ez, tag, ee, 1'b0}) begin
        failures++;
        $display("FAIL rand_rsp op=%h got=%h exp=%h", op, {r, z, t, e, m}, {er, ez, tag, ee, 1'b0});
      end
      checks++;
      if (lat != elat) begin failures++; $display("FAIL rand_latency op=%h got=%0d exp=%0d", op, lat, elat); end
      checks++;
      if (us != 0 || ia !== 1'b1) begin
        failures++;
        $display("FAIL rand_handshake unstable=%0d idle_after=%b exp=0/1", us, ia);
      end
      checks++;
      if (op_count !== 16'(exp_count)) begin
        failures++;
        $display("FAIL rand_op_count got=%0d exp=%0d", op_count, exp_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q_res[$]; logic [3:0] q_tag[$];
    int last_acc, gaps_bad, n_acc, n_rsp;
    logic acc;
    last_acc = -1; gaps_bad = 0; n_acc = 0; n_rsp = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'($urandom_range(0, 10));
    cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_tag = 4'd0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (n_acc >= 6 && q_res.size() == 0) break;
      acc = 1'b0;
      if (rsp_valid) begin
        checks++;
        if (q_res.size() == 0 || rsp_result !== q_res[0] || rsp_tag !== q_tag[0]) begin
          failures++;
          $display("FAIL b2b_rsp got=%h/%h exp=%h/%h", rsp_result, rsp_tag,
                   (q_res.size() > 0) ? q_res[0] : 64'd0, (q_tag.size() > 0) ? q_tag[0] : 4'd0);
        end
        if (q_res.size() > 0) begin void'(q_res.pop_front()); void'(q_tag.pop_front()); end
        n_rsp++; exp_count++;
      end
      if (cmd_valid && cmd_ready) begin
        q_res.push_back(ref_alu(cmd_op, cmd_a, cmd_b)); q_tag.push_back(cmd_tag);
        if (last_acc >= 0 && cyc - last_acc != 5) gaps_bad++;
        last_acc = cyc; n_acc++; acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        cmd_op = 4'($urandom_range(0, 10));
        cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom};
        cmd_tag = 4'(n_acc);
      end
      if (n_acc >= 6) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (gaps_bad != 0) begin failures++; $display("FAIL b2b_period bad_gaps=%0d exp=0", gaps_bad); end
    checks++;
    if (n_rsp != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", n_rsp); end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL b2b_op_count got=%0d exp=%0d", op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [63:0] r; logic z, e, m, ia; logic [3:0] t; int lat, us;
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 64'd100; cmd_b = 64'd23; cmd_tag = 4'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    exp_count = 0;
    checks++;
    if ({rsp_valid, alu_op, op_count} !== {1'b0, 4'hF, 16'd0}) begin
      failures++;
      $display("FAIL midreset_ctrl got=%h exp=%h", {rsp_valid, alu_op, op_count}, {1'b0, 4'hF, 16'd0});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(4'h2, 64'hF0F0, 64'hFF00, 4'd2, 0, r, z, t, e, m, lat, us, ia);
    checks++;
    if ({r, t, op_count} !== {64'hF000, 4'd2, 16'd1}) begin
      failures++;
      $display("FAIL midreset_recover got=%h exp=%h", {r, t, op_count}, {64'hF000, 4'd2, 16'd1});
    end
  endtask

`ifdef ALU_SEQ_CHECK_EN
  task automatic test_mismatch();
    logic [63:0] r; logic z, e, m, ia; logic [3:0] t; int lat, us;
    inject_xor = 1'b1;
    run_cmd(4'h4, 64'h1234, 64'h00FF, 4'd4, 0, r, z, t, e, m, lat, us, ia);
    inject_xor = 1'b0;
    checks++;
    if (m !== 1'b1) begin failures++; $display("FAIL mismatch_flag got=%b exp=1", m); end
    run_cmd(4'h4, 64'h1234, 64'h00FF, 4'd5, 0, r, z, t, e, m, lat, us, ia);
    checks++;
    if (m !== 1'b0) begin failures++; $display("FAIL mismatch_clear got=%b exp=0", m); end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_illegal();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
`ifdef ALU_SEQ_CHECK_EN
    test_mismatch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
